// File: rtl/store_buffer_if.sv
// ---------------------------------------------------------------------------
// store_buffer_if
// Bundles every non-clock/reset signal of the store buffer.
//   master : LSU / arbiter / load-pipe side (drives enq_*, drain_ready,
//            stall, lookup_*; observes the rest)
//   slave  : the store buffer itself
// Signals:
//   enq_valid/enq_ready/enq_addr/enq_data/enq_wmask : commit-side enqueue
//   drain_valid/drain_ready/drain_addr/drain_data/drain_wmask : L1 write port
//   stall                                 : arbiter busy, hold off draining
//   lookup_valid/lookup_addr              : load lookup request
//   store_hit/fwd_data/fwd_wmask          : lookup result (youngest match)
//   count/empty/full                      : occupancy status
// ---------------------------------------------------------------------------
interface store_buffer_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int MASK_W = DATA_W / 8;

  logic              enq_valid;
  logic              enq_ready;
  logic [ADDR_W-1:0] enq_addr;
  logic [DATA_W-1:0] enq_data;
  logic [MASK_W-1:0] enq_wmask;

  logic              drain_valid;
  logic              drain_ready;
  logic [ADDR_W-1:0] drain_addr;
  logic [DATA_W-1:0] drain_data;
  logic [MASK_W-1:0] drain_wmask;

  logic              stall;

  logic              lookup_valid;
  logic [ADDR_W-1:0] lookup_addr;
  logic              store_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [MASK_W-1:0] fwd_wmask;

  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;

  modport master (
    output enq_valid, enq_addr, enq_data, enq_wmask,
    output drain_ready, stall, lookup_valid, lookup_addr,
    input  enq_ready, drain_valid, drain_addr, drain_data, drain_wmask,
    input  store_hit, fwd_data, fwd_wmask, count, empty, full
  );

  modport slave (
    input  enq_valid, enq_addr, enq_data, enq_wmask,
    input  drain_ready, stall, lookup_valid, lookup_addr,
    output enq_ready, drain_valid, drain_addr, drain_data, drain_wmask,
    output store_hit, fwd_data, fwd_wmask, count, empty, full
  );
endinterface

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Circular FIFO of committed stores sitting between the LSU commit port and
// the L1 D-cache write port, with a combinational youngest-match load lookup.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous active-high reset, discards all entries
//   sb  : store_buffer_if.slave (enqueue, drain, stall, lookup, status)
// The interface instance must be built with the same DEPTH/ADDR_W/DATA_W.
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave sb
);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;
  localparam int MASK_W = DATA_W / 8;

  // Every entry is compared in parallel by the lookup, so storage is flops
  // with combinational read rather than a block RAM.
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [MASK_W-1:0] mask_mem [DEPTH];

  // Pointers carry one extra wrap bit above the index.
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [IDX_W-1:0] head_idx, tail_idx;
  logic [PTR_W-1:0] count_w;
  logic             empty_w, full_w;
  logic             enq_fire, drain_valid_w, pop_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty_w  = (head_q == tail_q);
  assign full_w   = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  // Modulo 2*DEPTH difference yields 0..DEPTH thanks to the wrap bit.
  assign count_w  = tail_q - head_q;

  // Full blocks enqueue even if a pop happens this cycle: no bypass.
  assign enq_fire      = sb.enq_valid && !full_w;
  assign drain_valid_w = !empty_w && !sb.stall;
  assign pop_fire      = drain_valid_w && sb.drain_ready;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (enq_fire) tail_d = tail_q + PTR_W'(1);
    if (pop_fire) head_d = head_q + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Entry contents are not cleared on reset; occupancy comes from pointers.
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      addr_mem[tail_idx] <= sb.enq_addr;
      data_mem[tail_idx] <= sb.enq_data;
      mask_mem[tail_idx] <= sb.enq_wmask;
    end
  end

  // Status and drain port
  assign sb.enq_ready   = !full_w;
  assign sb.count       = count_w;
  assign sb.empty       = empty_w;
  assign sb.full        = full_w;
  assign sb.drain_valid = drain_valid_w;
  assign sb.drain_addr  = empty_w ? '0 : addr_mem[head_idx];
  assign sb.drain_data  = empty_w ? '0 : data_mem[head_idx];
  assign sb.drain_wmask = empty_w ? '0 : mask_mem[head_idx];

  // Lookup: per-slot age relative to head and word-address match.
  logic [IDX_W-1:0] age_w [DEPTH];
  logic [DEPTH-1:0] match_w;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign age_w[gi]   = IDX_W'(gi) - head_idx;
      // A slot is occupied when its age is below the current occupancy.
      assign match_w[gi] = sb.lookup_valid
                         && (PTR_W'(age_w[gi]) < count_w)
                         && (addr_mem[gi][ADDR_W-1:2] == sb.lookup_addr[ADDR_W-1:2]);
    end
  endgenerate

  // Youngest match = largest age among matching slots.
  logic             hit_w;
  logic [IDX_W-1:0] best_age;
  logic [IDX_W-1:0] sel_idx;

  always_comb begin
    hit_w    = 1'b0;
    best_age = '0;
    sel_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_w[i] && (!hit_w || age_w[i] > best_age)) begin
        hit_w    = 1'b1;
        best_age = age_w[i];
        sel_idx  = IDX_W'(i);
      end
    end
  end

  assign sb.store_hit = hit_w;
  assign sb.fwd_data  = hit_w ? data_mem[sel_idx] : '0;
  assign sb.fwd_wmask = hit_w ? mask_mem[sel_idx] : '0;

  // Byte offset of the load address is irrelevant to a word-granular match.
  logic unused_lookup_lsb;
  assign unused_lookup_lsb = ^sb.lookup_addr[1:0];
endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
// Directed scenarios followed by a randomized phase, all checked every cycle
// against a queue-based reference model of the store buffer.
// ---------------------------------------------------------------------------
module tb_store_buffer;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } entry_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  entry_t model_q[$];

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) sb_if ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                        input logic [3:0] em, input logic dr, input logic st,
                        input logic lv, input logic [31:0] la);
    sb_if.enq_valid    = ev;
    sb_if.enq_addr     = ea;
    sb_if.enq_data     = ed;
    sb_if.enq_wmask    = em;
    sb_if.drain_ready  = dr;
    sb_if.stall        = st;
    sb_if.lookup_valid = lv;
    sb_if.lookup_addr  = la;
  endtask

  // Reference lookup: youngest matching word address, no merging.
  task automatic model_lookup(input logic lv, input logic [31:0] la, output logic hit,
                              output logic [31:0] d, output logic [3:0] m);
    hit = 1'b0; d = '0; m = '0;
    if (lv) begin
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (model_q[i].addr[31:2] == la[31:2]) begin
          hit = 1'b1; d = model_q[i].data; m = model_q[i].mask;
          break;
        end
      end
    end
  endtask

  // Let combinational outputs settle, then compare all of them with the model.
  task automatic settle_check();
    logic        e_hit;
    logic [31:0] e_d;
    logic [3:0]  e_m;
    entry_t      hd;
    int          n;
    #1;
    n  = model_q.size();
    hd = (n > 0) ? model_q[0] : '0;
    model_lookup(sb_if.lookup_valid, sb_if.lookup_addr, e_hit, e_d, e_m);
    chk("count",       64'(sb_if.count),       64'(n));
    chk("empty",       64'(sb_if.empty),       64'(n == 0));
    chk("full",        64'(sb_if.full),        64'(n == DEPTH));
    chk("enq_ready",   64'(sb_if.enq_ready),   64'(n != DEPTH));
    chk("drain_valid", 64'(sb_if.drain_valid), 64'((n > 0) && !sb_if.stall));
    chk("drain_addr",  64'(sb_if.drain_addr),  64'(hd.addr));
    chk("drain_data",  64'(sb_if.drain_data),  64'(hd.data));
    chk("drain_wmask", 64'(sb_if.drain_wmask), 64'(hd.mask));
    chk("store_hit",   64'(sb_if.store_hit),   64'(e_hit));
    chk("fwd_data",    64'(sb_if.fwd_data),    64'(e_d));
    chk("fwd_wmask",   64'(sb_if.fwd_wmask),   64'(e_m));
  endtask

  // Clock edge: update the model from the inputs presented this cycle.
  task automatic advance();
    logic   do_rst, do_enq, do_pop;
    entry_t ne;
    do_rst = rst;
    do_enq = sb_if.enq_valid && (model_q.size() < DEPTH);
    do_pop = (model_q.size() > 0) && !sb_if.stall && sb_if.drain_ready;
    ne     = '{addr: sb_if.enq_addr, data: sb_if.enq_data, mask: sb_if.enq_wmask};
    @(posedge clk);
    if (do_rst) model_q.delete();
    else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(ne);
    end
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    advance();
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    advance();
    advance();
    rst = 1'b0;

    // Reset state
    settle_check();
    chk("rst_count", 64'(sb_if.count), 64'd0);
    chk("rst_empty", 64'(sb_if.empty), 64'd1);
    chk("rst_enq_ready", 64'(sb_if.enq_ready), 64'd1);
    chk("rst_drain_valid", 64'(sb_if.drain_valid), 64'd0);

    // Single enqueue, visible next cycle, then drained
    set_in(1'b1, 32'h100, 32'h11111111, 4'hF, 1'b0, 1'b0, 1'b0, '0);
    step();
    set_in(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    settle_check();
    chk("first_drain_valid", 64'(sb_if.drain_valid), 64'd1);
    chk("first_drain_addr", 64'(sb_if.drain_addr), 64'h100);
    advance();
    idle();
    settle_check();
    chk("after_pop_empty", 64'(sb_if.empty), 64'd1);
    chk("after_pop_count", 64'(sb_if.count), 64'd0);

    // Fill to full across the pointer wrap
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'h1000 + 32'(4 * i), $urandom, 4'(i + 1), 1'b0, 1'b0, 1'b0, '0);
      step();
    end
    idle();
    settle_check();
    chk("fill_full", 64'(sb_if.full), 64'd1);
    chk("fill_enq_ready", 64'(sb_if.enq_ready), 64'd0);
    chk("fill_count", 64'(sb_if.count), 64'd8);
    set_in(1'b1, 32'hDEAD0, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b0, '0);
    step();
    idle();
    settle_check();
    chk("ninth_dropped_count", 64'(sb_if.count), 64'd8);
    // Full plus pop while enqueuing: enqueue must still be refused
    set_in(1'b1, 32'hBAD0, 32'h0BAD0BAD, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    settle_check();
    chk("full_pop_enq_ready", 64'(sb_if.enq_ready), 64'd0);
    advance();
    idle();
    settle_check();
    chk("pop_from_full", 64'(sb_if.full), 64'd0);
    chk("pop_from_full_count", 64'(sb_if.count), 64'd7);
    for (int i = 1; i < DEPTH; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
      settle_check();
      chk("fifo_order", 64'(sb_if.drain_addr), 64'(32'h1000 + 32'(4 * i)));
      advance();
    end

    // Youngest-match forwarding
    set_in(1'b1, 32'h200, 32'hAAAAAAAA, 4'h3, 1'b0, 1'b0, 1'b0, '0);
    step();
    set_in(1'b1, 32'h200, 32'hBBBBBBBB, 4'hC, 1'b0, 1'b0, 1'b0, '0);
    step();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h202);
    settle_check();
    chk("lookup_hit", 64'(sb_if.store_hit), 64'd1);
    chk("lookup_data", 64'(sb_if.fwd_data), 64'hBBBBBBBB);
    chk("lookup_mask", 64'(sb_if.fwd_wmask), 64'hC);
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h204);
    settle_check();
    chk("lookup_miss", 64'(sb_if.store_hit), 64'd0);
    chk("lookup_miss_data", 64'(sb_if.fwd_data), 64'd0);
    advance();

    // Stall suppresses draining
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, '0, '0, 1'b1, 1'b1, 1'b0, '0);
      settle_check();
      chk("stall_no_offer", 64'(sb_if.drain_valid), 64'd0);
      advance();
    end
    idle();
    settle_check();
    chk("stall_count", 64'(sb_if.count), 64'd2);
    set_in(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    settle_check();
    chk("unstall_data", 64'(sb_if.drain_data), 64'hAAAAAAAA);
    advance();
    idle();
    settle_check();
    chk("unstall_count", 64'(sb_if.count), 64'd1);

    // Bring to 4, then simultaneous enqueue and pop
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h500 + 32'(4 * i), $urandom, 4'hF, 1'b0, 1'b0, 1'b0, '0);
      step();
    end
    set_in(1'b1, 32'h50C, 32'h5555AAAA, 4'h5, 1'b1, 1'b0, 1'b0, '0);
    step();
    idle();
    settle_check();
    chk("enq_pop_count", 64'(sb_if.count), 64'd4);

    // Same-cycle enqueue is invisible to lookup
    set_in(1'b1, 32'h300, 32'h33333333, 4'hF, 1'b0, 1'b0, 1'b1, 32'h300);
    settle_check();
    chk("same_cycle_invisible", 64'(sb_if.store_hit), 64'd0);
    advance();
    set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, 32'h300);
    settle_check();
    chk("next_cycle_visible", 64'(sb_if.store_hit), 64'd1);
    chk("next_cycle_data", 64'(sb_if.fwd_data), 64'h33333333);
    chk("pre_rst_count", 64'(sb_if.count), 64'd5);
    advance();

    // Reset mid-operation, inputs ignored during reset
    rst = 1'b1;
    set_in(1'b1, 32'h700, 32'h77777777, 4'hF, 1'b1, 1'b0, 1'b0, '0);
    step();
    rst = 1'b0;
    idle();
    settle_check();
    chk("mid_rst_count", 64'(sb_if.count), 64'd0);
    chk("mid_rst_empty", 64'(sb_if.empty), 64'd1);
    chk("mid_rst_drain_valid", 64'(sb_if.drain_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      logic [31:0] la;
      la = 32'h100 * 32'(i + 1);
      set_in(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, la);
      settle_check();
      chk("mid_rst_no_hit", 64'(sb_if.store_hit), 64'd0);
    end
    advance();

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic [31:0] ea, la;
      ea = 32'h400 + 32'($urandom_range(0, 5) * 4) + 32'($urandom_range(0, 3));
      la = 32'h400 + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3));
      rst = ($urandom_range(0, 99) == 0);
      set_in(($urandom_range(0, 3) != 0), ea, $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) != 0), la);
      step();
    end
    rst = 1'b0;
    idle();
    settle_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Circular FIFO of committed stores between the LSU commit port and the L1 D-cache write port. It accepts one store per cycle, drains the oldest store into the L1 cache when the cache arbiter is not stalling, and answers a same-cycle load lookup with hit, data and byte-mask from the youngest matching entry. The arbiter checks `store_hit` in parallel with its tag lookup. It raises `stall` while allocating a block on a miss repair.

## Interface
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; mask width is `DATA_W/8`
- `clk` in 1: single clock; all state updates on the rising edge
- `rst` in 1: reset is synchronous and active-high
- `enq_valid` in 1: committed store presented
- `enq_ready` out 1: equals `!full`
- `enq_addr` in ADDR_W: byte address; word address is `enq_addr[ADDR_W-1:2]`
- `enq_data` in DATA_W: data, already lane-aligned
- `enq_wmask` in DATA_W/8: byte enables; an all-zero mask is enqueued unchanged
- `drain_valid` out 1: oldest entry offered to the cache
- `drain_ready` in 1: cache accepts the write this cycle
- `drain_addr` out ADDR_W / `drain_data` out DATA_W / `drain_wmask` out DATA_W/8: head entry fields
- `stall` in 1: arbiter is allocating; draining is suppressed
- `lookup_valid` in 1: load lookup request
- `lookup_addr` in ADDR_W: load byte address; compared on the word address
- `store_hit` out 1: a valid entry matches
- `fwd_data` out DATA_W / `fwd_wmask` out DATA_W/8: youngest matching entry's fields; zero when no hit
- `count` out $clog2(DEPTH)+1: number of occupied entries
- `empty` out 1 / `full` out 1

## Operation
- Storage: DEPTH entries of {addr, data, wmask}. Head and tail pointers are each $clog2(DEPTH)+1 bits, with the MSB used as a wrap bit.
- Empty/full: `empty` = (head == tail). `full` = index bits equal and wrap bits differ.
- Enqueue fires on `enq_valid && enq_ready`. The entry is written at tail and tail increments modulo 2·DEPTH.
- Drain: `drain_valid = !empty && !stall`. Pop fires on `drain_valid && drain_ready`, and head increments.
- Simultaneous enqueue and pop: `count` is unchanged and both pointers advance.
- Full plus pop in the same cycle: `enq_ready` stays 0, so there is no same-cycle bypass. The slot frees on the next cycle.
- `stall` rising while `drain_valid` is high: the offer is withdrawn that cycle and no pop occurs. The head entry is held unchanged.
- Lookup is purely combinational on registered state.
  - `store_hit = lookup_valid` && some occupied entry has a matching word address.
  - Priority: youngest first, meaning the nearest to tail−1 walking back to head. Age is computed as (idx − head) mod DEPTH.
  - Same-cycle visibility: a store enqueued this cycle is not visible to the lookup. A store popped this cycle is still visible.
  - The lookup does not merge bytes across entries. The consumer compares `fwd_wmask` against the load's needs.
- No coalescing is performed and entries are never flushed. Only committed stores enter the buffer.
- Reset values:
  - head=tail=0, `count`=0, `empty`=1, `full`=0, `enq_ready`=1
  - `drain_valid`=0, `store_hit`=0, `fwd_*`=0, `drain_*`=0 when empty
  - Entry contents need not be cleared.
- Reset asserted mid-operation discards all entries on that edge. Inputs are ignored during the reset cycle.

## Timing
- Enqueue to visibility: 1 cycle. An entry enqueued at edge N is offered on `drain_*` and matched by lookup in cycle N+1 at the earliest.
- Drain handshake: `drain_*` holds stable while `drain_valid && !drain_ready`.
- Throughput: 1 enqueue plus 1 pop per cycle.
- Lookup: 0 cycles, combinational from `lookup_addr` and state.
- Pointer arithmetic wraps silently. The wrap bit disambiguates full from empty when `count` is DEPTH versus 0.

## Test plan
- Reset, then enqueue A=0x100/D=0x11111111/M=0xF: next cycle `drain_valid`=1 with drain_addr=0x100. Pulse `drain_ready` → `empty`=1 and `count`=0.
- Fill 8 entries with `drain_ready`=0: `full`=1, `enq_ready`=0, `count`=8. A ninth `enq_valid` is dropped. One pop → `full`=0 the next cycle, and order is preserved FIFO through pointer wrap.
- Two entries to 0x200: first data 0xAAAAAAAA/mask 0x3, then 0xBBBBBBBB/0xC. Lookup 0x202 → `store_hit`=1, fwd_data=0xBBBBBBBB, fwd_wmask=0xC. Lookup 0x204 → `store_hit`=0.
- Non-empty buffer with `stall`=1 and `drain_ready`=1 for 3 cycles: `drain_valid`=0 and `count` unchanged. Deassert `stall` → the head entry pops.
- Simultaneous enqueue and pop at `count`=4 → `count` stays 4. Enqueue 0x300 and look up 0x300 in the same cycle → `store_hit`=0 that cycle and 1 the next.
- Assert `rst` with `count`=5 → next cycle `count`=0, `empty`=1, `drain_valid`=0, `store_hit`=0 for all addresses.
